// File: rtl/pkt_rd_ctrl.sv
// Packet read engine: fetches one buffered packet over an Avalon-MM burst master
// and streams it out on a valid/ready interface, ending with a one-cycle rdy pulse.
module pkt_rd_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int BURST_MAX  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [ADDR_W-1:0]          i_base_addr,
  input  logic [LEN_W-1:0]           i_length_bytes,
  output logic                       o_busy,
  output logic                       o_rdy,
  output logic [ADDR_W-1:0]          o_avm_address,
  output logic                       o_avm_read,
  output logic [$clog2(BURST_MAX):0] o_avm_burstcount,
  input  logic                       i_avm_waitrequest,
  input  logic [31:0]                i_avm_readdata,
  input  logic                       i_avm_readdatavalid,
  output logic [31:0]                o_out_data,
  output logic                       o_out_valid,
  output logic                       o_out_last,
  input  logic                       i_out_ready
);

  localparam int WORDS_W = LEN_W - 1;
  localparam int BC_W    = $clog2(BURST_MAX) + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SUM_W   = CNT_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_rdy;
  logic               r_avm_read;
  logic [ADDR_W-1:0]  r_avm_address;
  logic [BC_W-1:0]    r_burstcount;
  logic [WORDS_W-1:0] r_req_rem;
  logic [WORDS_W-1:0] r_emit_rem;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_fifo_count;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [31:0]        r_mem [FIFO_DEPTH];

  logic [WORDS_W-1:0] w_words;
  logic [WORDS_W-1:0] w_req_nxt;
  logic [BC_W-1:0]    w_first_b;
  logic [BC_W-1:0]    w_next_b;
  logic               w_push;
  logic               w_pop;
  logic               w_accept;
  logic               w_room;
  logic [CNT_W-1:0]   w_fifo_count_nxt;
  logic [CNT_W-1:0]   w_outstanding_nxt;
  logic [SUM_W-1:0]   w_need;

  // Word count is ceil(bytes/4); the extra bit absorbs the round-up carry.
  assign w_words  = WORDS_W'(i_length_bytes[LEN_W-1:2]) + WORDS_W'(|i_length_bytes[1:0]);
  assign w_push   = i_avm_readdatavalid && (r_state != S_IDLE);
  assign w_pop    = o_out_valid && i_out_ready;
  assign w_accept = r_avm_read && !i_avm_waitrequest;

  assign w_req_nxt = r_req_rem - (w_accept ? WORDS_W'(r_burstcount) : '0);
  assign w_first_b = (w_words >= WORDS_W'(BURST_MAX)) ? BC_W'(BURST_MAX) : BC_W'(w_words);
  assign w_next_b  = (w_req_nxt >= WORDS_W'(BURST_MAX)) ? BC_W'(BURST_MAX) : BC_W'(w_req_nxt);

  assign w_fifo_count_nxt  = r_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_outstanding_nxt = r_outstanding + (w_accept ? CNT_W'(r_burstcount) : '0) - CNT_W'(w_push);

  // Next burst only if every word already in flight plus this burst still fits.
  assign w_need = SUM_W'(w_fifo_count_nxt) + SUM_W'(w_outstanding_nxt) + SUM_W'(w_next_b);
  assign w_room = (w_need <= SUM_W'(FIFO_DEPTH));

  assign o_busy           = r_busy;
  assign o_rdy            = r_rdy;
  assign o_avm_read       = r_avm_read;
  assign o_avm_address    = r_avm_address;
  assign o_avm_burstcount = r_burstcount;
  assign o_out_valid      = (r_fifo_count != '0);
  assign o_out_last       = o_out_valid && (r_emit_rem == WORDS_W'(1));
  assign o_out_data       = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_rdy         <= 1'b0;
      r_avm_read    <= 1'b0;
      r_avm_address <= '0;
      r_burstcount  <= '0;
      r_req_rem     <= '0;
      r_emit_rem    <= '0;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (w_pop) r_emit_rem <= r_emit_rem - WORDS_W'(1);
      case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b0;
          if (i_start) begin
            r_busy     <= 1'b1;
            r_req_rem  <= w_words;
            r_emit_rem <= w_words;
            if (w_words == '0) begin
              r_state <= S_DONE;
              r_rdy   <= 1'b1;
            end else begin
              r_state       <= S_ISSUE;
              r_avm_read    <= 1'b1;
              r_avm_address <= {i_base_addr[ADDR_W-1:2], 2'b00};
              r_burstcount  <= w_first_b;
            end
          end
        end
        S_ISSUE: begin
          r_req_rem <= w_req_nxt;
          if (w_accept) r_avm_address <= r_avm_address + ADDR_W'({r_burstcount, 2'b00});
          if (r_avm_read && i_avm_waitrequest) begin
            r_avm_read <= 1'b1;
          end else if (w_req_nxt == '0) begin
            r_avm_read <= 1'b0;
            r_state    <= S_DRAIN;
          end else if (w_room) begin
            r_avm_read   <= 1'b1;
            r_burstcount <= w_next_b;
          end else begin
            r_avm_read <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_pop && o_out_last) begin
            r_state <= S_DONE;
            r_rdy   <= 1'b1;
          end
        end
        S_DONE: begin
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word FIFO; data arriving while idle is a protocol error and is dropped.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_avm_readdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_fifo_count <= w_fifo_count_nxt;
    end
  end

endmodule

// File: tb/tb_pkt_rd_ctrl.sv
// Directed bench for pkt_rd_ctrl: Avalon-MM slave model with optional stalls,
// stream sink with optional backpressure, and expected data from a memory model.
module tb_pkt_rd_ctrl;

  localparam int ADDR_W     = 32;
  localparam int LEN_W      = 16;
  localparam int BURST_MAX  = 8;
  localparam int FIFO_DEPTH = 32;
  localparam int BC_W       = $clog2(BURST_MAX) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] baseAddr = '0;
  logic [LEN_W-1:0]  lengthBytes = '0;
  logic              busy;
  logic              rdy;
  logic [ADDR_W-1:0] avmAddress;
  logic              avmRead;
  logic [BC_W-1:0]   avmBurstcount;
  logic              avmWaitrequest = 1'b0;
  logic [31:0]       avmReaddata = '0;
  logic              avmReaddatavalid = 1'b0;
  logic [31:0]       outData;
  logic              outValid;
  logic              outLast;
  logic              outReady = 1'b0;

  int checkCnt = 0;
  int passCnt  = 0;
  int failCnt  = 0;

  int stallMode = 0;
  int readyMode = 1;
  int cycle = 0;
  logic [31:0] wordQ[$];
  logic [31:0] gotQ[$];
  bit          lastQ[$];
  logic [31:0] burstAddrQ[$];
  int          burstLenQ[$];
  int gap = 0;
  int reqWords = 0;
  int poppedWords = 0;
  int occErrs = 0;
  int stallErrs = 0;
  int rdyCount = 0;
  int readSeen = 0;
  int lastHsCycle = -1;
  int rdyCycle = -1;
  bit prevStall = 1'b0;
  logic [ADDR_W-1:0] prevAddr = '0;
  logic [BC_W-1:0]   prevBc = '0;

  pkt_rd_ctrl #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_MAX(BURST_MAX), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_start(start),
    .i_base_addr(baseAddr),
    .i_length_bytes(lengthBytes),
    .o_busy(busy),
    .o_rdy(rdy),
    .o_avm_address(avmAddress),
    .o_avm_read(avmRead),
    .o_avm_burstcount(avmBurstcount),
    .i_avm_waitrequest(avmWaitrequest),
    .i_avm_readdata(avmReaddata),
    .i_avm_readdatavalid(avmReaddatavalid),
    .o_out_data(outData),
    .o_out_valid(outValid),
    .o_out_last(outLast),
    .i_out_ready(outReady)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  // Slave and sink act at the falling edge: outputs are settled and the inputs
  // driven here are the ones the next rising edge samples.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      wordQ.delete();
      gap = 0;
      prevStall = 1'b0;
      avmWaitrequest = 1'b0;
      avmReaddatavalid = 1'b0;
      outReady = 1'b0;
    end else begin
      if (rdy) begin
        rdyCount++;
        rdyCycle = cycle;
      end
      if (avmRead) readSeen++;
      if (prevStall && !(avmRead === 1'b1 && avmAddress === prevAddr && avmBurstcount === prevBc))
        stallErrs++;
      if (gap > 0) begin
        gap--;
        avmReaddatavalid = 1'b0;
      end else if (wordQ.size() > 0) begin
        avmReaddatavalid = 1'b1;
        avmReaddata = memWord(wordQ.pop_front());
        gap = (stallMode != 0) ? int'($urandom_range(0, 9)) : 0;
      end else begin
        avmReaddatavalid = 1'b0;
      end
      avmWaitrequest = (stallMode != 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      prevStall = avmRead && avmWaitrequest;
      prevAddr = avmAddress;
      prevBc = avmBurstcount;
      if (avmRead && !avmWaitrequest) begin
        burstAddrQ.push_back(avmAddress);
        burstLenQ.push_back(int'(avmBurstcount));
        for (int i = 0; i < int'(avmBurstcount); i++) wordQ.push_back(avmAddress + 32'(4 * i));
        reqWords += int'(avmBurstcount);
      end
      outReady = (readyMode == 2) ? 1'($urandom_range(0, 1)) : (readyMode == 1);
      if (outValid && outReady) begin
        gotQ.push_back(outData);
        lastQ.push_back(outLast);
        poppedWords++;
        if (outLast) lastHsCycle = cycle;
      end
      if (reqWords - poppedWords > FIFO_DEPTH) occErrs++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCnt++;
    assert (observed === expected) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] base, input int len);
    gotQ.delete();
    lastQ.delete();
    burstAddrQ.delete();
    burstLenQ.delete();
    reqWords = 0;
    poppedWords = 0;
    occErrs = 0;
    stallErrs = 0;
    rdyCount = 0;
    readSeen = 0;
    lastHsCycle = -1;
    rdyCycle = -1;
    @(negedge clk);
    baseAddr = base;
    lengthBytes = LEN_W'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int limit);
    int n = 0;
    while (rdyCount == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " done"}, 32'(rdyCount != 0), 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, " single rdy"}, 32'(rdyCount), 32'd1);
    checkOutput({tag, " busy low"}, 32'(busy), 32'd0);
  endtask

  task automatic checkStream(input string tag, input logic [31:0] base, input int nWords);
    int bad = 0;
    int lastBad = 0;
    checkOutput({tag, " word count"}, 32'(gotQ.size()), 32'(nWords));
    foreach (gotQ[i]) begin
      if (gotQ[i] !== memWord(base + 32'(4 * i))) bad++;
      if (lastQ[i] !== (i == nWords - 1)) lastBad++;
    end
    checkOutput({tag, " bad words"}, 32'(bad), 32'd0);
    checkOutput({tag, " bad last flags"}, 32'(lastBad), 32'd0);
    checkOutput({tag, " rdy after last"}, 32'(rdyCycle - lastHsCycle), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rdy", 32'(rdy), 32'd0);
    checkOutput("reset avm_read", 32'(avmRead), 32'd0);
    checkOutput("reset avm_address", avmAddress, 32'd0);
    checkOutput("reset burstcount", 32'(avmBurstcount), 32'd0);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset out_last", 32'(outLast), 32'd0);
    checkOutput("reset out_data", outData, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] aligned packet");
    applyStimulus(32'h1000, 64);
    checkOutput("aligned busy at T+1", 32'(busy), 32'd1);
    checkOutput("aligned read at T+1", 32'(avmRead), 32'd1);
    checkOutput("aligned first address", avmAddress, 32'h1000);
    checkOutput("aligned first burstcount", 32'(avmBurstcount), 32'd8);
    waitDone("aligned", 500);
    checkOutput("aligned burst count", 32'(burstAddrQ.size()), 32'd2);
    checkOutput("aligned burst0 addr", burstAddrQ[0], 32'h1000);
    checkOutput("aligned burst1 addr", burstAddrQ[1], 32'h1020);
    checkOutput("aligned burst0 len", 32'(burstLenQ[0]), 32'd8);
    checkOutput("aligned burst1 len", 32'(burstLenQ[1]), 32'd8);
    checkStream("aligned", 32'h1000, 16);

    $display("[TB] odd length");
    applyStimulus(32'h2002, 13);
    checkOutput("odd address aligned", avmAddress, 32'h2000);
    checkOutput("odd burstcount", 32'(avmBurstcount), 32'd4);
    waitDone("odd", 500);
    checkOutput("odd burst count", 32'(burstAddrQ.size()), 32'd1);
    checkStream("odd", 32'h2000, 4);

    $display("[TB] zero length");
    applyStimulus(32'h3000, 0);
    checkOutput("zero rdy at T+1", 32'(rdy), 32'd1);
    checkOutput("zero busy at T+1", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("zero rdy at T+2", 32'(rdy), 32'd0);
    checkOutput("zero busy at T+2", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("zero no avm_read", 32'(readSeen), 32'd0);
    checkOutput("zero rdy pulses", 32'(rdyCount), 32'd1);
    checkOutput("zero no words", 32'(gotQ.size()), 32'd0);

    $display("[TB] backpressure");
    readyMode = 0;
    applyStimulus(32'h10000, 256);
    repeat (100) @(negedge clk);
    checkOutput("bp nothing popped", 32'(poppedWords), 32'd0);
    checkOutput("bp requested fills fifo", 32'(reqWords), 32'd32);
    checkOutput("bp out_valid held", 32'(outValid), 32'd1);
    checkOutput("bp occupancy while held", 32'(occErrs), 32'd0);
    readyMode = 1;
    waitDone("bp", 2000);
    checkOutput("bp occupancy overall", 32'(occErrs), 32'd0);
    checkStream("bp", 32'h10000, 64);

    $display("[TB] slave stalls");
    stallMode = 1;
    readyMode = 2;
    applyStimulus(32'h20000, 100);
    waitDone("stall", 5000);
    checkOutput("stall addr/bc stable", 32'(stallErrs), 32'd0);
    checkOutput("stall occupancy", 32'(occErrs), 32'd0);
    checkOutput("stall burst count", 32'(burstAddrQ.size()), 32'd4);
    checkOutput("stall tail burst len", 32'(burstLenQ[3]), 32'd1);
    checkStream("stall", 32'h20000, 25);
    stallMode = 0;
    readyMode = 1;

    $display("[TB] abort during drain");
    readyMode = 0;
    applyStimulus(32'h5000, 64);
    n = 0;
    while (burstAddrQ.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checkOutput("abort data buffered", 32'(outValid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy cleared", 32'(busy), 32'd0);
    checkOutput("abort fifo flushed", 32'(outValid), 32'd0);
    checkOutput("abort read dropped", 32'(avmRead), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort no rdy", 32'(rdyCount), 32'd0);
    readyMode = 1;
    applyStimulus(32'h6000, 32);
    @(negedge clk);
    baseAddr = 32'h7000;
    lengthBytes = LEN_W'(8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("restart", 500);
    checkOutput("restart burst count", 32'(burstAddrQ.size()), 32'd1);
    checkOutput("restart burst addr", burstAddrQ[0], 32'h6000);
    checkStream("restart", 32'h6000, 8);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
